uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_MAX, default 8, meaning the maximum data bits per frame (legal 5..8).
REQ-002 SHALL have parameter BAUD_DIV_W, default 16, meaning the width of the baud divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port tx_data_i  input  DATA_MAX  word to send, LSB first; unused upper bits ignored.
REQ-007 SHALL have port valid_i  input  1  write request for tx_data_i.
REQ-008 SHALL have port ready_o  output  1  FIFO can accept a word.
REQ-009 SHALL have port baud_div_i  input  BAUD_DIV_W  clock cycles per bit.
REQ-010 SHALL have port data_bits_i  input  4  data bits per frame.
REQ-011 SHALL have port two_stop_bits_i  input  1  1 = two stop bits, 0 = one.
REQ-012 SHALL have port parity_en_i  input  1  append parity bit.
REQ-013 SHALL have port parity_odd_i  input  1  1 = odd parity, 0 = even.
REQ-014 SHALL have port tx_pin_o  output  1  serial line, idle high, registered.
REQ-015 SHALL have port busy_o  output  1  FSM not in IDLE.
REQ-016 SHALL have port fifo_count_o  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Function
REQ-017 SHALL accept a word on a cycle with valid_i && ready_o; ready_o = !full, independent of a same-cycle pop, so a full FIFO rejects pushes.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL pop the FIFO in IDLE when not empty, or in the last cycle of the final stop bit when not empty; START follows on the next cycle, with no idle gap between back-to-back frames.
REQ-020 SHALL not bypass the FIFO: a word pushed into an empty FIFO is popped on the following cycle.
REQ-021 SHALL latch baud_div_i, data_bits_i, two_stop_bits_i, parity_en_i and parity_odd_i at pop; mid-frame input changes affect only the next frame.
REQ-022 SHALL hold each bit on tx_pin_o for exactly baud_div_i cycles; baud_div_i = 0 SHALL be treated as 1.
REQ-023 SHALL clamp data_bits_i: values below 5 become 5, values above DATA_MAX become DATA_MAX.
REQ-024 SHALL send the frame as: START low, N data bits LSB first, optional PARITY, then 1 or 2 STOP high.
REQ-025 SHALL compute parity over the N sent bits only: even = XOR of bits, odd = inverted XOR.
REQ-026 SHALL have transitions START->DATA, DATA->PARITY when parity is enabled, otherwise DATA->STOP, PARITY->STOP, and STOP->START (FIFO not empty) or STOP->IDLE.
REQ-027 SHALL drive tx_pin_o high in IDLE and in the unreachable-state default, which returns to IDLE.

Reset
REQ-028 SHALL, with rst_n low at a clock edge, set tx_pin_o=1, ready_o=1, busy_o=0, fifo_count_o=0, state IDLE and the FIFO flushed.
REQ-029 SHALL abort any frame in progress when reset is asserted mid-frame; the line is high from the cycle after that edge and no partial frame resumes.

Configuration
REQ-030 SHALL, with macro UART_TX_PARITY_EN defined, include the PARITY state and honour parity_en_i and parity_odd_i.
REQ-031 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and its logic, ignore parity_en_i and parity_odd_i, and never send a parity bit.

Structure
REQ-032 SHALL take the state enum type_uart_tx_cfg_states_e, the minimum data-bit constant (5) and default widths from the shared UART package/defs.
REQ-033 SHALL place the FIFO in sub-module uart_tx_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-034 SHALL check: baud_div=4, 8N1, push 0xA5 -> low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; frame is 40 cycles.
REQ-035 SHALL check: 7 bits, even parity, push 0x41 -> data 1,0,0,0,0,0,1, parity 0, one stop; with odd parity, parity bit 1.
REQ-036 SHALL check: baud_div=2, hold valid_i high while a frame is in progress -> exactly 4 words accepted, ready_o=0, fifo_count_o=4, then all frames back-to-back with no idle cycle.
REQ-037 SHALL check: data_bits_i=3 -> 5 data bits sent; data_bits_i=15 -> 8 data bits sent; baud_div=0 -> 1 cycle per bit.
REQ-038 SHALL check: rst_n low during DATA bit 3 with 2 words queued -> tx_pin_o=1 and fifo_count_o=0 next cycle, with no further frames.
REQ-039 SHALL check: change data_bits_i from 8 to 6 during a frame -> current frame sends 8 bits and the next frame sends 6.

Source files
------------

// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg -- shared definitions for the configurable UART transmitter.
//   State enum type_uart_tx_cfg_states_e, minimum data-bit count, default widths
//   and the data-bit clamp helper.
// Config macro: UART_TX_PARITY_EN adds the StParity state to the enum.
package uart_tx_cfg_pkg;

  localparam int unsigned DataBitsMin      = 5;
  localparam int unsigned DataMaxDefault   = 8;
  localparam int unsigned BaudDivWDefault  = 16;
  localparam int unsigned FifoDepthDefault = 4;
  localparam int unsigned DataBitsW        = 4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } type_uart_tx_cfg_states_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } type_uart_tx_cfg_states_e;
`endif

  // Clamp a requested data-bit count into [DataBitsMin, max_bits].
  function automatic logic [DataBitsW-1:0] clamp_data_bits(logic [DataBitsW-1:0] req,
                                                           int unsigned max_bits);
    if (32'(req) < DataBitsMin) return DataBitsW'(DataBitsMin);
    if (32'(req) > max_bits) return DataBitsW'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous FIFO holding words waiting to be transmitted.
//   clk, rst_n        : clock, synchronous active-low reset (flushes the FIFO)
//   push_i, wdata_i   : write request and data (ignored when full)
//   pop_i, rdata_o    : read request (ignored when empty), head-of-queue data
//   full_o, empty_o   : occupancy flags
//   count_o           : number of occupied entries
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0]   CntFull = Depth[AddrW:0];
  localparam logic [AddrW:0]   CntOne  = 1;
  localparam logic [AddrW-1:0] PtrOne  = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- UART transmitter with runtime frame configuration and TX FIFO.
//   clk, rst_n          : clock, synchronous active-low reset (aborts frame, flushes FIFO)
//   tx_data_i, valid_i  : word to send (LSB first) and write request
//   ready_o             : FIFO not full
//   baud_div_i          : clock cycles per bit (0 treated as 1)
//   data_bits_i         : data bits per frame, clamped to 5..DATA_MAX
//   two_stop_bits_i     : 1 = two stop bits
//   parity_en_i         : append parity bit (parity builds only)
//   parity_odd_i        : 1 = odd parity (parity builds only)
//   tx_pin_o            : registered serial line, idle high
//   busy_o              : transmitter not idle
//   fifo_count_o        : occupied FIFO entries
// Config macro: UART_TX_PARITY_EN enables the parity state; without it the
// parity inputs are ignored and no parity bit is ever sent.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned DATA_MAX   = DataMaxDefault,
  parameter int unsigned BAUD_DIV_W = BaudDivWDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_MAX-1:0]         tx_data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [BAUD_DIV_W-1:0]       baud_div_i,
  input  logic [DataBitsW-1:0]        data_bits_i,
  input  logic                        two_stop_bits_i,
  input  logic                        parity_en_i,
  input  logic                        parity_odd_i,
  output logic                        tx_pin_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  type_uart_tx_cfg_states_e state_q, state_d;

  logic [BAUD_DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_DIV_W-1:0] div_q, div_d;
  logic [DataBitsW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DataBitsW-1:0]  nbits_q, nbits_d;
  logic [DATA_MAX-1:0]   shift_q, shift_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_pin_q, tx_pin_d;

  logic                  fifo_full, fifo_empty, pop;
  logic [DATA_MAX-1:0]   fifo_rdata;
  logic                  baud_end;
  logic [DataBitsW-1:0]  nbits_in;
  logic [BAUD_DIV_W-1:0] div_in;

  assign nbits_in = clamp_data_bits(data_bits_i, DATA_MAX);
  assign div_in   = (baud_div_i == '0) ? BAUD_DIV_W'(1) : baud_div_i;
  assign baud_end = (baud_cnt_q == div_q - BAUD_DIV_W'(1));

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic frame_par;

  // Parity of the word about to be popped, over the clamped bit count only.
  always_comb begin
    frame_par = parity_odd_i;
    for (int unsigned i = 0; i < DATA_MAX; i++) begin
      if (i < 32'(nbits_in)) frame_par = frame_par ^ fifo_rdata[i];
    end
  end
`else
  logic unused_parity;
  assign unused_parity = parity_en_i ^ parity_odd_i;
`endif

  uart_tx_fifo #(
    .Width (DATA_MAX),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (valid_i),
    .wdata_i (tx_data_i),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      div_q      <= BAUD_DIV_W'(1);
      bit_cnt_q  <= '0;
      nbits_q    <= DataBitsW'(DATA_MAX);
      shift_q    <= '0;
      two_stop_q <= 1'b0;
      tx_pin_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      two_stop_q <= two_stop_d;
      tx_pin_q   <= tx_pin_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  // Next-state logic. bit_cnt counts data bits in StData and stop bits in StStop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    shift_d    = shift_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    case (state_q)
      StIdle: begin
        if (!fifo_empty) pop = 1'b1;
      end
      StStart: begin
        if (baud_end) begin
          state_d    = StData;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_DIV_W'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == nbits_q - DataBitsW'(1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = par_en_q ? StParity : StStop;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + DataBitsW'(1);
            shift_d   = shift_q >> 1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_end) begin
          state_d    = StStop;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_DIV_W'(1);
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == {{(DataBitsW-1){1'b0}}, two_stop_q}) begin
            // Last cycle of the final stop bit: chain straight into the next frame.
            if (!fifo_empty) pop = 1'b1;
            else state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + DataBitsW'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame configuration is captured only here, so mid-frame input changes
    // apply to the next frame.
    if (pop) begin
      state_d    = StStart;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      div_d      = div_in;
      nbits_d    = nbits_in;
      two_stop_d = two_stop_bits_i;
      shift_d    = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_en_d   = parity_en_i;
      par_bit_d  = frame_par;
`endif
    end
  end

  // Line level is derived from the next state so the registered pin lines up
  // with state_q.
  always_comb begin
    tx_pin_d = 1'b1;
    case (state_d)
      StStart:  tx_pin_d = 1'b0;
      StData:   tx_pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_pin_d = par_bit_d;
`endif
      default:  tx_pin_d = 1'b1;
    endcase
  end

  assign tx_pin_o = tx_pin_q;
  assign busy_o   = (state_q != StIdle);
  assign ready_o  = !fifo_full;

endmodule
